y4_packer: RTL

Y4_PACKER -- requirements
Module: y4_packer

---
 rtl/caster_pkg.sv | 26 ++
 rtl/y4_packer_if.sv | 13 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/y4_packer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/caster_pkg.sv
// Constants and types shared by the Y4 packing pipeline: default raster geometry,
// the 4x4 Bayer threshold matrix and the FIFO word layout.
package caster_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1600;
  localparam int unsigned V_ACTIVE_DEF = 1200;
  localparam int unsigned Y4_W         = 4;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned WORD_W       = Y4_W * PIX_PER_WORD;
  localparam int unsigned FIFO_DEPTH   = 8;

  // Nibble {row,col} holds T[row][col]; row 0 is {0,8,2,10}.
  localparam logic [63:0] BAYER_M = 64'h5D7F_91B3_6E4C_A280;

  typedef struct packed {
    logic              sof;
    logic [WORD_W-1:0] pix;
  } y4_word_t;

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    int unsigned idx;
    idx = {28'd0, row, col};
    return BAYER_M[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/y4_packer_if.sv
// Output stream of packed Y4 words: valid/ready handshake with a start-of-frame marker.
interface y4_packer_if ();
  import caster_pkg::*;

  logic [WORD_W-1:0] vout_pixel;
  logic              vout_vsync;
  logic              vout_valid;
  logic              vout_ready;

  modport master (output vout_pixel, output vout_vsync, output vout_valid, input vout_ready);
  modport slave  (input vout_pixel, input vout_vsync, input vout_valid, output vout_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; a write while full is accepted only when a
// read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_rd_en,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_wr, w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_rd_en & ~o_empty;
  assign w_wr    = i_wr_en & (~o_full | w_rd);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/y4_packer.sv
// Quantises 8-bit luma to 4 bits with optional ordered dither, packs four pixels per
// 16-bit word and streams them through a small FIFO, flagging overflow and bad geometry.
module y4_packer
  import caster_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter bit          DITHER_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vid_vsync,
  input  logic               vid_hsync,
  input  logic               vid_de,
  input  logic [7:0]         vid_y,
  y4_packer_if.master        vout,
  output logic               ovf,
  output logic               fmt_err
);
  localparam logic [10:0] HActive = 11'(H_ACTIVE);
  localparam logic [10:0] VActive = 11'(V_ACTIVE);

  logic         r_vs_q, r_hs_q, r_de_q;
  logic [10:0]  r_x, r_y, w_x_nxt, w_y_nxt, w_x_eff, w_y_eff;
  logic [15:0]  r_acc, w_acc_nxt, w_acc_ins, w_pad_mask;
  logic         r_first, r_armed, r_sof_pend, w_sof_pend_nxt;
  logic         r_push, w_push_nxt;
  y4_word_t     r_word, w_word_nxt, w_rdata;
  logic         r_ovf, r_fmt, r_vs_clr;
  logic         w_vs_rise, w_hs_rise, w_de_fall, w_pix, w_line_err, w_frame_err;
  logic [8:0]   w_sum;
  logic [3:0]   w_q;
  logic         w_full, w_empty, w_pop;

  assign w_vs_rise = vid_vsync & ~r_vs_q;
  assign w_hs_rise = vid_hsync & ~r_hs_q;
  assign w_de_fall = r_de_q & ~vid_de;
  // Sync takes effect before a coincident pixel, so it sees x=0, y=0.
  assign w_x_eff   = (w_vs_rise | w_hs_rise) ? 11'd0 : r_x;
  assign w_y_eff   = w_vs_rise ? 11'd0 : r_y;
  assign w_pix     = vid_de & (r_armed | w_vs_rise);

  assign w_sum = {1'b0, vid_y} + {5'd0, bayer(w_y_eff[1:0], w_x_eff[1:0])};
  assign w_q   = DITHER_EN ? (w_sum[8] ? 4'hF : w_sum[7:4]) : vid_y[7:4];

  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[{w_x_eff[1:0], 2'b00} +: 4] = w_q;
    case (r_x[1:0])
      2'd1:    w_pad_mask = 16'h000F;
      2'd2:    w_pad_mask = 16'h00FF;
      2'd3:    w_pad_mask = 16'h0FFF;
      default: w_pad_mask = 16'h0000;
    endcase
  end

  always_comb begin
    w_x_nxt        = w_x_eff;
    w_y_nxt        = w_y_eff;
    w_acc_nxt      = r_acc;
    w_push_nxt     = 1'b0;
    w_word_nxt     = r_word;
    w_sof_pend_nxt = r_sof_pend | w_vs_rise;
    w_line_err     = 1'b0;
    if (w_pix) begin
      w_x_nxt   = w_x_eff + 11'd1;
      w_acc_nxt = w_acc_ins;
      if (w_x_eff[1:0] == 2'd3) begin
        w_push_nxt     = 1'b1;
        w_word_nxt     = '{sof: r_sof_pend, pix: w_acc_ins};
        w_sof_pend_nxt = 1'b0;
      end
    end else if (r_armed && w_de_fall && !w_vs_rise) begin
      w_y_nxt    = r_y + 11'd1;
      w_line_err = (r_x != HActive);
      if (r_x[1:0] != 2'd0) begin
        w_push_nxt     = 1'b1;
        w_word_nxt     = '{sof: r_sof_pend, pix: r_acc & w_pad_mask};
        w_sof_pend_nxt = 1'b0;
      end
    end
  end

  assign w_frame_err = w_vs_rise & ~r_first & (r_y != VActive);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_q     <= 1'b0;
      r_hs_q     <= 1'b0;
      r_de_q     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      r_first    <= 1'b1;
      r_armed    <= 1'b0;
      r_sof_pend <= 1'b0;
      r_push     <= 1'b0;
      r_word     <= '0;
      r_ovf      <= 1'b0;
      r_fmt      <= 1'b0;
      r_vs_clr   <= 1'b0;
    end else begin
      r_vs_q     <= vid_vsync;
      r_hs_q     <= vid_hsync;
      r_de_q     <= vid_de;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_acc      <= w_acc_nxt;
      r_sof_pend <= w_sof_pend_nxt;
      r_push     <= w_push_nxt;
      r_word     <= w_word_nxt;
      r_vs_clr   <= w_vs_rise;
      if (w_vs_rise) begin
        r_first <= 1'b0;
        r_armed <= 1'b1;
      end
      r_ovf <= w_vs_rise ? 1'b0 : (r_ovf | (r_push & w_full & ~w_pop));
      // The frame verdict is shown for one cycle, then the new frame starts clean.
      r_fmt <= w_vs_rise ? w_frame_err : ((r_fmt & ~r_vs_clr) | w_line_err);
    end
  end

  sync_fifo #(
    .Width($bits(y4_word_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (r_push),
    .i_wdata (r_word),
    .i_rd_en (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop           = vout.vout_ready & ~w_empty;
  assign vout.vout_valid = ~w_empty;
  assign vout.vout_pixel = w_empty ? '0 : w_rdata.pix;
  assign vout.vout_vsync = ~w_empty & w_rdata.sof;
  assign ovf             = r_ovf;
  assign fmt_err         = r_fmt;

endmodule
